// File: rtl/simon_pkg.sv
// simon_pkg: SIMON constant sequences, round counts and rotate/round helpers
// shared by every stage of the pipeline.
package simon_pkg;

   localparam logic [0:61] Z [0:4] = '{
      62'b11111010001001010110000111001101111101000100101011000011100110,
      62'b10001110111110010011000010110101000111011111001001100001011010,
      62'b10101111011100000011010010011000101000010001111110010110110011,
      62'b11011011101011000110010111100000010010001010011100110100001111,
      62'b11010001111001101011011000100000010111000011001010010011101111
   };

   // Zero marks an unsupported (N,M) pair.
   function automatic int rounds_of(input int n, input int m);
      return (n == 16 && m == 4) ? 32 : (n == 24 && m == 3) ? 36 : (n == 24 && m == 4) ? 36 :
             (n == 32 && m == 3) ? 42 : (n == 32 && m == 4) ? 44 : 0;
   endfunction

   function automatic int zidx_of(input int n, input int m);
      return (n == 24 && m == 4) ? 1 : (n == 32 && m == 3) ? 2 : (n == 32 && m == 4) ? 3 : 0;
   endfunction

   // Rotations operate on the low n bits of a 32-bit container.
   function automatic logic [31:0] rotl(input logic [31:0] x, input int n, input int s);
      logic [31:0] mask;
      mask = (n == 32) ? '1 : ((32'd1 << n) - 32'd1);
      return ((x << s) | (x >> (n - s))) & mask;
   endfunction

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n, input int s);
      return rotl(x, n, n - s);
   endfunction

   function automatic logic [31:0] round_f(input logic [31:0] x, input int n);
      return (rotl(x, n, 1) & rotl(x, n, 8)) ^ rotl(x, n, 2);
   endfunction

endpackage

// File: rtl/simon_stage.sv
// simon_stage: up to RPS SIMON rounds with on-the-fly key expansion,
// followed by the stage register that loads only when en is high.
module simon_stage
   import simon_pkg::*;
#(
   parameter int N     = 16,
   parameter int M     = 4,
   parameter int RPS   = 1,
   parameter int FIRST = 0,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             src_valid,
   input  logic [N-1:0]     src_x,
   input  logic [N-1:0]     src_y,
   input  logic [M*N-1:0]   src_key,
   input  logic [TAG_W-1:0] src_tag,
   output logic             valid,
   output logic [N-1:0]     x,
   output logic [N-1:0]     y,
   output logic [M*N-1:0]   key,
   output logic [TAG_W-1:0] tag
);

   localparam int ROUNDS = rounds_of(N, M);
   localparam int ZI     = zidx_of(N, M);
   localparam int CNT    = (FIRST + RPS > ROUNDS) ? ROUNDS - FIRST : RPS;

   logic [N-1:0]   cx, cy, t, nk;
   logic [M*N-1:0] ck;

   // The key window slides by one word per round; its low word is the round key.
   always_comb begin
      cx = src_x;
      cy = src_y;
      ck = src_key;
      t  = '0;
      nk = '0;
      for (int r = 0; r < CNT; r++) begin
         t = N'(rotr(32'(ck[M*N-1 -: N]), N, 3));
         if (M == 4) t = t ^ ck[2*N-1:N];
         t = t ^ N'(rotr(32'(t), N, 1));
         nk = ~ck[N-1:0] ^ t ^ N'(Z[ZI][6'((FIRST + r) % 62)]) ^ N'(3);
         {cx, cy} = {cy ^ N'(round_f(32'(cx), N)) ^ ck[N-1:0], cx};
         ck = {nk, ck[M*N-1:N]};
      end
   end

   always_ff @(posedge clk)
      if (!rst) begin
         valid <= 1'b0;
         x     <= '0;
         y     <= '0;
         key   <= '0;
         tag   <= '0;
      end else if (en) begin
         valid <= src_valid;
         x     <= cx;
         y     <= cy;
         key   <= ck;
         tag   <= src_tag;
      end

endmodule

// File: rtl/simon_pipe_core_param.sv
// simon_pipe_core_param: pipelined SIMON 2N/MN encryption with a global
// valid/ready advance and a tag carried beside each block.
module simon_pipe_core_param
   import simon_pkg::*;
#(
   parameter int N     = 16,
   parameter int M     = 4,
   parameter int RPS   = 1,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*N-1:0]   plaintext,
   input  logic [M*N-1:0]   key,
   input  logic [TAG_W-1:0] tag_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*N-1:0]   ciphertext,
   output logic [TAG_W-1:0] tag_out
);

   localparam int ROUNDS = rounds_of(N, M);
   localparam int STAGES = (RPS > 0) ? (ROUNDS + RPS - 1) / RPS : 1;

   if (ROUNDS == 0 || RPS < 1 || RPS > ROUNDS || TAG_W < 1) begin : g_bad
      $error("simon_pipe_core_param: illegal N/M/RPS/TAG_W combination");
   end

   logic                adv;
   logic [STAGES:0]     v;
   logic [N-1:0]        x [STAGES+1];
   logic [N-1:0]        y [STAGES+1];
   logic [M*N-1:0]      k [STAGES+1];
   logic [TAG_W-1:0]    t [STAGES+1];

   // The whole pipe moves together; it freezes only when the output is blocked.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   assign v[0]          = in_valid;
   assign {x[0], y[0]}  = plaintext;
   assign k[0]          = key;
   assign t[0]          = tag_in;

   for (genvar s = 0; s < STAGES; s++) begin : g_s
      simon_stage #(.N(N), .M(M), .RPS(RPS), .FIRST(s * RPS), .TAG_W(TAG_W)) u_stage (
         .clk      (clk),
         .rst      (rst),
         .en       (adv),
         .src_valid(v[s]),
         .src_x    (x[s]),
         .src_y    (y[s]),
         .src_key  (k[s]),
         .src_tag  (t[s]),
         .valid    (v[s+1]),
         .x        (x[s+1]),
         .y        (y[s+1]),
         .key      (k[s+1]),
         .tag      (t[s+1])
      );
   end

   assign out_valid  = v[STAGES];
   assign ciphertext = {x[STAGES], y[STAGES]};
   assign tag_out    = t[STAGES];

endmodule

// File: doc/simon_pipe_core_param.md
Name: simon_pipe_core_param

Overview:
Parametrised, fully pipelined SIMON block-cipher encryption core covering the SIMON 2N/MN family: 32/64, 48/72, 48/96, 64/96 and 64/128. It generalises the fixed 32-round SIMON32/64 pipeline in four ways:
- selectable word and key size;
- configurable rounds per register stage;
- valid/ready handshaking with backpressure;
- a sideband tag carried alongside each block.
It sits between the host load logic and the ciphertext consumer, and accepts one block per cycle when not stalled.

Parameters:
N, 16, word size in bits; legal values 16, 24, 32.
M, 4, key words; legal values 3 or 4, with (N,M) restricted to the five legal pairs. Any other pair is an elaboration error.
RPS, 1, rounds per pipeline stage (1..ROUNDS).
TAG_W, 4, sideband tag width (at least 1).
Derived, not overridable:
- ROUNDS = 32/36/36/42/44 for 32/64, 48/72, 48/96, 64/96, 64/128.
- Z index = 0/0/1/2/3 for the same pairs.
- STAGES = ceil(ROUNDS/RPS).

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
in_valid  in  1  input block valid
in_ready  out  1  core can accept the input this cycle
plaintext  in  2N  plaintext, {x,y}; x is the upper N bits
key  in  M*N  key, {k[M-1],...,k[0]}; k[0] is the low N bits
tag_in  in  TAG_W  sideband tag travelling with the block
out_valid  out  1  ciphertext valid
out_ready  in  1  consumer accepts the output
ciphertext  out  2N  ciphertext, {x,y}
tag_out  out  TAG_W  tag of the block on the output

Behaviour:
- Round function: x' = y ^ f(x) ^ k_i; y' = x; f(x) = (x<<<1 & x<<<8) ^ (x<<<2). Rotations are within N bits.
- Key expansion, computed on the fly per round. Each stage carries a window of M round keys k[i..i+M-1]:
  - tmp = k[i+M-1]>>>3
  - if M==4: tmp ^= k[i+1]
  - tmp ^= tmp>>>1
  - k[i+M] = ~k[i] ^ tmp ^ z[(i) mod 62] ^ 3
  - The constant 3 and z are zero-extended to N bits. k_i is the lowest word of the window.
- Stage s (0..STAGES-1) applies rounds s*RPS up to min((s+1)*RPS, ROUNDS)-1 combinationally, then registers {valid, x, y, key window, tag}. If RPS does not divide ROUNDS, the last stage is shorter.
- Global advance: adv = !out_valid || out_ready. All stage registers load only when adv=1; otherwise all hold.
- in_ready = adv, combinational.
- A block is accepted when in_valid && in_ready. The stage-0 valid loads in_valid && adv. Non-accepted cycles insert bubbles (valid=0).
- Latency: a block accepted on edge t appears with out_valid=1 after edge t+STAGES-1.
  - With RPS=1 on 32/64 that is 32 cycles.
  - Sustained throughput is 1 block/cycle when out_ready=1.
- Outputs are direct from the last stage register; no combinational path from plaintext to ciphertext.
- While out_valid && !out_ready, ciphertext and tag_out hold stable, and the input is not accepted.
- Order is preserved; blocks never drop or duplicate.
- Reset (rst=0 at clk edge):
  - all valid bits clear to 0;
  - data, key and tag registers clear to 0;
  - out_valid=0, ciphertext=0, tag_out=0, in_ready=1 on the cycle after.
  - Reset mid-stream discards all in-flight blocks, and it overrides a simultaneous accept.
- Simultaneous output pop and input accept in the same cycle is legal and does not stall.
- Reset overrides every other input.
- No decryption mode in this block.

Decomposition:
- Package simon_pkg holds:
  - the Z constant array (five 62-bit sequences z0..z4);
  - functions rounds_of(N,M) and zidx_of(N,M);
  - generic rotl/rotr helpers;
  - function round_f.
- Sub-module simon_stage, one per pipeline stage, parametrised by N, M, RPS and first-round index FIRST. It is combinational rounds followed by the stage register, with an enable port driven by adv.
- The top level contains only the generate loop, the handshake and the parameter check.

Test Plan:
- 32/64, RPS=1: key 1918_1110_0908_0100, pt 6565_6877, tag 5 -> ct c69b_e9bb, tag_out 5, out_valid exactly 32 cycles after accept.
- 48/96, RPS=4: key 1a1918_121110_0a0908_020100, pt 726963_20646e -> ct 6e06a5_acf156, latency 9.
- 64/128, RPS=5 (non-dividing, 9 stages): key 1b1a1918_13121110_0b0a0908_03020100, pt 656b696c_20646e75 -> ct 44c8fc20_b9dfa07a.
- 32/64, 8 back-to-back blocks with out_ready toggling 1,0,0,1,...:
  - outputs match the reference model in order, with no loss or duplication;
  - ciphertext is stable while stalled;
  - in_ready=0 exactly when out_valid && !out_ready.
- Sparse in_valid (1 of every 3 cycles) -> bubbles propagate; out_valid pattern matches the input pattern delayed by STAGES.
- Reset asserted with 10 blocks in flight -> next cycle out_valid=0, ciphertext=0, in_ready=1. The next block then encrypts correctly, and no stale block ever appears.
